// File: rtl/cell_fetch_stream.sv
// Streams one frame of cells in raster order from the cell cache to the HOG datapath.
// Read issue is credit-limited so returning data always has a reserved buffer slot.
module cell_fetch_stream #(
  parameter int CELL_WIDTH     = 768,
  parameter int FRAME_ROW_CNUM = 30,
  parameter int FRAME_COL_CNUM = 40,
  parameter int MEM_LAT        = 2,
  parameter int BUF_DEPTH      = MEM_LAT + 1,
  localparam int CELL_NUM      = FRAME_ROW_CNUM * FRAME_COL_CNUM,
  localparam int CELL_ADDR_W   = $clog2(CELL_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [CELL_ADDR_W-1:0] bwd_cell_addr_o,
  output logic                   bwd_cell_rd_vld_o,
  input  logic [CELL_WIDTH-1:0]  bwd_cell_data_i,
  input  logic                   bwd_cell_rd_rdy_i,
  output logic [CELL_WIDTH-1:0]  fwd_cell_data_o,
  output logic [3:0]             fwd_cell_border_o,
  output logic                   fwd_cell_valid_o,
  input  logic                   fwd_cell_ready_i
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // FETCH  | issuing reads, forwarding returned cells
  // ISSUED | all reads issued, draining to the last handshake
  // FLUSH  | aborted, dropping returns until nothing is in flight

  localparam int ROW_W = (FRAME_ROW_CNUM > 1) ? $clog2(FRAME_ROW_CNUM) : 1;
  localparam int COL_W = (FRAME_COL_CNUM > 1) ? $clog2(FRAME_COL_CNUM) : 1;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = CNT_W + 2;

  localparam logic [CELL_ADDR_W-1:0] LAST_ADDR = CELL_ADDR_W'(CELL_NUM - 1);
  localparam logic [ROW_W-1:0]       LAST_ROW  = ROW_W'(FRAME_ROW_CNUM - 1);
  localparam logic [COL_W-1:0]       LAST_COL  = COL_W'(FRAME_COL_CNUM - 1);
  localparam logic [PTR_W-1:0]       LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [OCC_W-1:0]       DEPTH_OCC = OCC_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0]       ONE_CNT   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUED = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CELL_ADDR_W-1:0] addr;
  logic [CNT_W-1:0]       inflight;
  logic [CNT_W-1:0]       buf_count;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CELL_WIDTH-1:0]  fifo_mem [BUF_DEPTH];
  logic                   fwd_full;
  logic [CELL_WIDTH-1:0]  fwd_data;
  logic [ROW_W-1:0]       row;
  logic [COL_W-1:0]       col;

  logic             active;
  logic             abort_evt;
  logic             hs;
  logic             last_hs;
  logic             rd_issue;
  logic             rd_ret;
  logic             accept;
  logic             load_reg;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [OCC_W-1:0] occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign active     = (state == ST_FETCH) || (state == ST_ISSUED);
  assign abort_evt  = active & abort_i;
  assign hs         = fwd_full & fwd_cell_ready_i;
  assign last_hs    = hs & ~abort_evt & (row == LAST_ROW) & (col == LAST_COL);

  // A handshake in this cycle frees its slot immediately, which keeps full rate.
  assign occupancy  = OCC_W'(inflight) + OCC_W'(buf_count) + OCC_W'(fwd_full) - OCC_W'(hs);
  assign rd_issue   = (state == ST_FETCH) & ~abort_i & (occupancy < DEPTH_OCC);
  assign rd_ret     = bwd_cell_rd_rdy_i & (inflight != '0);
  assign accept     = rd_ret & active & ~abort_i;

  assign fifo_empty = (buf_count == '0);
  assign load_reg   = ~fwd_full | hs;
  assign fifo_pop   = load_reg & ~fifo_empty;
  // Returned data bypasses the FIFO when it is empty and the output slot frees up.
  assign fifo_push  = accept & ~(load_reg & fifo_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start_i && !abort_i) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (abort_i) state_nxt = ST_FLUSH;
        else if (rd_issue && (addr == LAST_ADDR)) state_nxt = ST_ISSUED;
      end
      ST_ISSUED: begin
        if (abort_i) state_nxt = ST_FLUSH;
        else if (last_hs) state_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        if ((inflight == '0) || ((inflight == ONE_CNT) && rd_ret)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o            = (state != ST_IDLE);
    bwd_cell_rd_vld_o = rd_issue;
    frame_done_o      = last_hs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if ((state == ST_IDLE) || abort_evt) begin
      addr <= '0;
    end else if (rd_issue) begin
      addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      unique case ({rd_issue, rd_ret})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
    end else if (abort_evt) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({fifo_push, fifo_pop})
        2'b10:   buf_count <= buf_count + 1'b1;
        2'b01:   buf_count <= buf_count - 1'b1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= bwd_cell_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_full <= 1'b0;
      fwd_data <= '0;
    end else if (abort_evt) begin
      fwd_full <= 1'b0;
    end else if (load_reg) begin
      if (!fifo_empty) begin
        fwd_full <= 1'b1;
        fwd_data <= fifo_mem[rd_ptr];
      end else if (accept) begin
        fwd_full <= 1'b1;
        fwd_data <= bwd_cell_data_i;
      end else begin
        fwd_full <= 1'b0;
      end
    end
  end

  // Position tracks the cell in the output register, so it advances on handshakes only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (abort_evt) begin
      row <= '0;
      col <= '0;
    end else if (hs) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign bwd_cell_addr_o   = addr;
  assign fwd_cell_valid_o  = fwd_full;
  assign fwd_cell_data_o   = fwd_data;
  assign fwd_cell_border_o = fwd_full ? {row == '0, row == LAST_ROW, col == '0, col == LAST_COL}
                                      : 4'b0000;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) assert (!(bwd_cell_rd_rdy_i && (inflight == '0)));
  end
`endif

endmodule

// File: tb/tb_cell_fetch_stream.sv
// Directed bench for cell_fetch_stream on a 3x4 frame, with a full-rate and a single-slot instance.
module tb_cell_fetch_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start0 = 0, abort0 = 0, ready0 = 0;
  logic        busy0, fdone0, vld0, rdy0, fvalid0;
  logic [3:0]  addr0, border0;
  logic [31:0] rdata0, fdata0;

  logic        start1 = 0, abort1 = 0, ready1 = 0;
  logic        busy1, fdone1, vld1, rdy1, fvalid1;
  logic [3:0]  addr1, border1;
  logic [31:0] rdata1, fdata1;

  logic [1:0]      pv0, pv1;
  logic [1:0][3:0] pa0, pa1;

  logic [3:0] bexp [12] = '{4'b1010, 4'b1000, 4'b1000, 4'b1001,
                            4'b0010, 4'b0000, 4'b0000, 4'b0001,
                            4'b0110, 4'b0100, 4'b0100, 4'b0101};

  function automatic logic [31:0] cell_data(input logic [3:0] a);
    return {28'hA500000, a};
  endfunction

  cell_fetch_stream #(.CELL_WIDTH(32), .FRAME_ROW_CNUM(3), .FRAME_COL_CNUM(4),
                      .MEM_LAT(2), .BUF_DEPTH(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .abort_i(abort0),
    .busy_o(busy0), .frame_done_o(fdone0),
    .bwd_cell_addr_o(addr0), .bwd_cell_rd_vld_o(vld0),
    .bwd_cell_data_i(rdata0), .bwd_cell_rd_rdy_i(rdy0),
    .fwd_cell_data_o(fdata0), .fwd_cell_border_o(border0),
    .fwd_cell_valid_o(fvalid0), .fwd_cell_ready_i(ready0));

  cell_fetch_stream #(.CELL_WIDTH(32), .FRAME_ROW_CNUM(3), .FRAME_COL_CNUM(4),
                      .MEM_LAT(2), .BUF_DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1),
    .busy_o(busy1), .frame_done_o(fdone1),
    .bwd_cell_addr_o(addr1), .bwd_cell_rd_vld_o(vld1),
    .bwd_cell_data_i(rdata1), .bwd_cell_rd_rdy_i(rdy1),
    .fwd_cell_data_o(fdata1), .fwd_cell_border_o(border1),
    .fwd_cell_valid_o(fvalid1), .fwd_cell_ready_i(ready1));

  // Cache models: data returns exactly two cycles after the read request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv0 <= '0; pa0 <= '0; pv1 <= '0; pa1 <= '0;
    end else begin
      pv0 <= {pv0[0], vld0}; pa0 <= {pa0[0], addr0};
      pv1 <= {pv1[0], vld1}; pa1 <= {pa1[0], addr1};
    end
  end
  assign rdy0   = pv0[1];
  assign rdata0 = cell_data(pa0[1]);
  assign rdy1   = pv1[1];
  assign rdata1 = cell_data(pa1[1]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int mode, input string tag);
    int idx = 0;
    int issued = 0;
    int occ_max = 0;
    int first_addr = -1;
    bit done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk); #1;
      start0 = (c == 0);
      ready0 = (mode == 0) || (c % 3 == 2);
      @(negedge clk);
      if (vld0) begin
        if (issued == 0) first_addr = int'(addr0);
        issued++;
      end
      if (fvalid0 && idx < 12) begin
        chk({tag, " data"}, fdata0, cell_data(idx[3:0]));
        chk({tag, " border"}, border0, bexp[idx]);
      end
      if (fvalid0 && ready0) begin
        chk({tag, " done"}, fdone0, (idx == 11));
        idx++;
        if (idx == 12) done = 1;
      end
      if (issued - idx > occ_max) occ_max = issued - idx;
    end
    chk({tag, " cells"}, idx, 12);
    chk({tag, " first_addr"}, first_addr, 0);
    chk({tag, " occ_le_3"}, (occ_max <= 3), 1'b1);
    @(posedge clk); #1;
    ready0 = 0;
    @(negedge clk);
    chk({tag, " busy_after"}, busy0, 1'b0);
  endtask

  initial begin
    bit saw_done;
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", busy0, 1'b0);
    chk("rst rd_vld", vld0, 1'b0);
    chk("rst fvalid", fvalid0, 1'b0);
    chk("rst border", border0, 4'b0000);
    chk("rst addr", addr0, 4'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // full-rate frame with hand-computed cycle timing; start/abort ignore cases at the end
    for (int k = 0; k <= 19; k++) begin
      @(posedge clk); #1;
      start0 = (k == 0) || (k == 15) || (k == 18);
      abort0 = (k == 18);
      ready0 = 1;
      @(negedge clk);
      chk("t1 rd_vld", vld0, (k >= 1 && k <= 12));
      if (k >= 1 && k <= 12) chk("t1 addr", addr0, k - 1);
      chk("t1 fvalid", fvalid0, (k >= 4 && k <= 15));
      if (k >= 4 && k <= 15) begin
        chk("t1 data", fdata0, cell_data(4'(k - 4)));
        chk("t1 border", border0, bexp[k - 4]);
      end
      chk("t1 done", fdone0, (k == 15));
      chk("t1 busy", busy0, (k >= 1 && k <= 15));
    end
    start0 = 0; abort0 = 0;

    // back-pressure: ready high one cycle in three
    run_frame(1, "t2");

    // abort mid-frame
    saw_done = 0;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      start0 = (k == 0);
      abort0 = (k == 6);
      ready0 = 1;
      @(negedge clk);
      if (fdone0) saw_done = 1;
      if (k >= 6) chk("t4 rd_vld", vld0, 1'b0);
      if (k == 7) begin
        chk("t4 fvalid", fvalid0, 1'b0);
        chk("t4 flush busy", busy0, 1'b1);
      end
      if (k == 9) chk("t4 idle", busy0, 1'b0);
    end
    chk("t4 no_done", saw_done, 1'b0);
    abort0 = 0; ready0 = 0;
    run_frame(0, "t4 restart");

    // single-slot buffer: one cell every three cycles
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      start1 = (k == 0);
      ready1 = 1;
      @(negedge clk);
      chk("t5 rd_vld", vld1, (k >= 1 && k <= 34 && (k - 1) % 3 == 0));
      chk("t5 fvalid", fvalid1, (k >= 4 && k <= 37 && (k - 4) % 3 == 0));
      if (k >= 4 && k <= 37 && (k - 4) % 3 == 0)
        chk("t5 data", fdata1, cell_data(4'((k - 4) / 3)));
      chk("t5 done", fdone1, (k == 37));
      chk("t5 busy", busy1, (k >= 1 && k <= 37));
    end
    start1 = 0; ready1 = 0;

    // asynchronous reset mid-frame
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      start0 = (k == 0);
      ready0 = 1;
    end
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6 busy", busy0, 1'b0);
    chk("t6 rd_vld", vld0, 1'b0);
    chk("t6 addr", addr0, 4'd0);
    chk("t6 fvalid", fvalid0, 1'b0);
    chk("t6 data", fdata0, 32'd0);
    chk("t6 border", border0, 4'b0000);
    chk("t6 done", fdone0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1; ready0 = 0;
    run_frame(0, "t6 restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
